// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline hazard / halt sequencing controller.
// Decides pc/IF-ID write enables and flushes from memory stalls, taken
// branches, load-use hazards, jumps and halts; drains the pipeline after
// HLT and parks in HALTED until reset.
// Optional build macro: HAZARD_STALL_CNT_EN enables the stall_cycles counter;
// when undefined stall_cycles is tied to zero.
module hazard_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [1:0]  id_rs1,
    input  logic [1:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [1:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        id_jump,
    input  logic        id_halt,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic [15:0] num_inst,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_drain_cnt;
    logic [1:0]  w_next_cnt;
    logic        r_halted;
    logic [15:0] r_num_inst;
    logic        w_load_use;
    logic        w_accept;
    logic        w_enter_drain;

    assign w_load_use = id_valid & ex_mem_read &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                         (id_uses_rs2 & (id_rs2 == ex_rd)));

    // An instruction moves into EX only in RUN when nothing of higher
    // precedence (busy, branch, load-use) claims the cycle; HLT counts here too.
    assign w_accept      = (r_state == ST_RUN) & ~mem_busy & ~ex_branch_taken &
                           ~w_load_use & id_valid;
    assign w_enter_drain = w_accept & ~id_jump & id_halt;

    // State, drain counter and halted flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_cnt;
            r_halted    <= (w_next_state == ST_HALTED);
        end
    end

    // Next-state and drain-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_drain_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_enter_drain) begin
                    w_next_state = ST_DRAIN;
                    w_next_cnt   = 2'd3;
                end
            end
            ST_DRAIN: begin
                if (!mem_busy) begin
                    w_next_cnt = r_drain_cnt - 2'd1;
                    if (r_drain_cnt == 2'd1) begin
                        w_next_state = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                w_next_state = ST_HALTED;
            end
            default: begin
                w_next_state = ST_RUN;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Pipeline register controls from state and current hazards.
    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mem_busy) begin
                    pc_write   = 1'b0;
                end else if (ex_branch_taken) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (w_load_use) begin
                    idex_flush = 1'b1;
                end else if (id_valid & id_jump) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = 1'b1;
                end else if (id_valid & id_halt) begin
                    ifid_flush = 1'b1;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
            end
            ST_DRAIN: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            default: begin
                pc_write   = 1'b0;
            end
        endcase
    end

    // Retired-into-EX instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num_inst <= '0;
        end else if (w_accept) begin
            r_num_inst <= r_num_inst + 16'd1;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    // Counts RUN cycles lost to memory busy or a load-use hazard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if ((r_state == ST_RUN) && (mem_busy || w_load_use)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

    assign halted   = r_halted;
    assign num_inst = r_num_inst;

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed vectors with a scoreboard queue; the driver
// pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_hazard_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [1:0]  id_rs1, id_rs2;
    logic        id_uses_rs1, id_uses_rs2;
    logic        ex_mem_read;
    logic [1:0]  ex_rd;
    logic        ex_branch_taken, id_jump, id_halt, mem_busy;
    logic        pc_write, ifid_write, ifid_flush, idex_flush;
    logic        halted;
    logic [15:0] num_inst, stall_cycles;

`ifdef HAZARD_STALL_CNT_EN
    localparam int SE = 1;
`else
    localparam int SE = 0;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic        hlt;
        logic [15:0] num;
        logic [15:0] stall;
    } exp_t;

    exp_t sb[$];

    hazard_sequencer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .id_jump         (id_jump),
        .id_halt         (id_halt),
        .mem_busy        (mem_busy),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .halted          (halted),
        .num_inst        (num_inst),
        .stall_cycles    (stall_cycles)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic chk_now(input string nm, input logic [3:0] c, input logic h,
                           input logic [15:0] n, input int st);
        chk({nm, ".ctrl"},  {12'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {12'd0, c});
        chk({nm, ".halted"}, {15'd0, halted}, {15'd0, h});
        chk({nm, ".num"},   num_inst, n);
        chk({nm, ".stall"}, stall_cycles, 16'(st * SE));
    endtask

    task automatic set_in(input logic v, input logic [1:0] r1, input logic [1:0] r2,
                          input logic u1, input logic u2, input logic mr, input logic [1:0] rd,
                          input logic br, input logic jp, input logic ht, input logic bz);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br; id_jump = jp;
        id_halt = ht; mem_busy = bz;
    endtask

    // Drive one cycle of inputs just after an edge and queue its expectation.
    task automatic vec(input string nm, input logic v, input logic [1:0] r1, input logic [1:0] r2,
                       input logic u1, input logic u2, input logic mr, input logic [1:0] rd,
                       input logic br, input logic jp, input logic ht, input logic bz,
                       input logic [3:0] c, input logic h, input logic [15:0] n, input int st);
        exp_t e;
        @(posedge clk);
        #1;
        set_in(v, r1, r2, u1, u2, mr, rd, br, jp, ht, bz);
        e.name = nm; e.ctrl = c; e.hlt = h; e.num = n; e.stall = 16'(st * SE);
        sb.push_back(e);
    endtask

    task automatic rst_pulse(input string nm);
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        chk_now(nm, 4'b1100, 1'b0, 16'h0000, 0);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: compare the oldest expectation mid-cycle, away from the edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.name, ".ctrl"},  {12'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {12'd0, e.ctrl});
            chk({e.name, ".halted"}, {15'd0, halted}, {15'd0, e.hlt});
            chk({e.name, ".num"},   num_inst, e.num);
            chk({e.name, ".stall"}, stall_cycles, e.stall);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk_now("reset", 4'b1100, 1'b0, 16'h0000, 0);
        #1;
        reset_n = 1'b1;

        //  name         v  r1 r2 u1 u2 mr rd br jp ht bz   ctrl    h  num    stall
        vec("normal",    1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 16'd0, 0);
        vec("lu_rs1",    1, 2, 0, 1, 0, 1, 2, 0, 0, 0, 0, 4'b0001, 0, 16'd1, 0);
        vec("lu_rs2",    1, 0, 3, 1, 1, 1, 3, 0, 0, 0, 0, 4'b0001, 0, 16'd1, 1);
        vec("no_use",    1, 1, 3, 1, 0, 1, 3, 0, 0, 0, 0, 4'b1100, 0, 16'd1, 2);
        vec("inv_id",    0, 2, 0, 1, 0, 1, 2, 0, 0, 0, 0, 4'b1100, 0, 16'd2, 2);
        vec("br_lu",     1, 2, 0, 1, 0, 1, 2, 1, 0, 0, 0, 4'b1111, 0, 16'd2, 2);
        vec("jump",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1110, 0, 16'd2, 3);
        vec("busy_jmp",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b0000, 0, 16'd3, 3);
        vec("busy_br",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 4'b0000, 0, 16'd3, 4);
        vec("jmp_hlt",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b1110, 0, 16'd3, 5);
        vec("normal2",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 16'd4, 5);
        vec("lu_hlt",    1, 2, 0, 1, 0, 1, 2, 0, 0, 1, 0, 4'b0001, 0, 16'd5, 5);
        vec("halt",      1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0010, 0, 16'd5, 6);
        vec("drain_br",  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0011, 0, 16'd6, 6);
        vec("drain2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 0, 16'd6, 6);
        for (int i = 0; i < 4; i++)
            vec("drain_busy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0011, 0, 16'd6, 6);
        vec("drain_last", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 0, 16'd6, 6);
        vec("halted1",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 1, 16'd6, 6);
        vec("halted2",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 16'd6, 6);

        rst_pulse("rst_halted");
        vec("post_rst_hlt", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0010, 0, 16'd0, 0);
        vec("drain_a",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 0, 16'd1, 0);
        rst_pulse("rst_drain");
        vec("after_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 16'd0, 0);
        vec("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 16'd1, 0);

        // Fill num_inst to 0xFFFF: 65533 edges here plus the next vector's edge.
        @(posedge clk);
        #1;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (65533) @(posedge clk);
        vec("wrap_ffff", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 16'hFFFF, 0);
        vec("wrap_0000", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 16'h0000, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
